// File: rtl/matrix_row_loader_pkg.sv
// Shared definitions for the matrix row loader: FSM state encodings and
// the width helper used to size the element and row counters.
package matrix_row_loader_pkg;

    typedef enum logic {
        FILL  = 1'b0,
        STALL = 1'b1
    } state_t;

    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

    // Counters always need at least one bit, even for a single row or element.
    function automatic int cnt_width(input int value);
        return (clog2(value) < 1) ? 1 : clog2(value);
    endfunction

endpackage

// File: rtl/matrix_row_loader_row_out_reg.sv
// Output register of the row loader: holds a complete row with its index
// and last flag until the downstream stage takes it.
module row_out_reg
    import matrix_row_loader_pkg::*;
#(
    parameter int row_width = 4,
    parameter int idx_width = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [row_width-1:0] load_row,
    input  logic [idx_width-1:0] load_idx,
    input  logic                 load_last,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [row_width-1:0] out_row,
    output logic [idx_width-1:0] out_idx,
    output logic                 out_last
);

    logic                 valid_q, valid_d;
    logic [row_width-1:0] row_q, row_d;
    logic [idx_width-1:0] idx_q, idx_d;
    logic                 last_q, last_d;

    // A load always wins: it may coincide with the transfer of the previous row.
    always_comb begin
        valid_d = valid_q;
        row_d   = row_q;
        idx_d   = idx_q;
        last_d  = last_q;
        if (load) begin
            valid_d = 1'b1;
            row_d   = load_row;
            idx_d   = load_idx;
            last_d  = load_last;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            row_q   <= '0;
            idx_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            row_q   <= row_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
        end
    end

    assign out_valid = valid_q;
    assign out_row   = row_q;
    assign out_idx   = idx_q;
    assign out_last  = last_q;

endmodule

// File: rtl/matrix_row_loader.sv
// Assembles serial row-major matrix elements into packed rows for the
// inner-product stage, stalling the input when a finished row cannot be handed off.
module matrix_row_loader
    import matrix_row_loader_pkg::*;
#(
    parameter int data_width = 2,
    parameter int num_elems  = 2,
    parameter int num_rows   = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [data_width-1:0]            in_data,
    input  logic                             in_valid,
    output logic                             in_ready,
    output logic [num_elems*data_width-1:0]  out_row,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [cnt_width(num_rows)-1:0]   out_row_idx,
    output logic                             out_last
);

    localparam int row_width = num_elems * data_width;
    localparam int elem_w    = cnt_width(num_elems);
    localparam int idx_w     = cnt_width(num_rows);

    state_t                 state_q, state_d;
    logic [elem_w-1:0]      elem_cnt_q, elem_cnt_d;
    logic [idx_w-1:0]       row_cnt_q, row_cnt_d;
    logic [row_width-1:0]   buf_q, buf_d;

    logic                   accept;
    logic                   out_free;
    logic                   last_elem;
    logic                   load;
    logic [row_width-1:0]   row_asm;
    logic [row_width-1:0]   load_row;
    logic                   load_last;

    assign in_ready  = !rst && (state_q == FILL);
    assign accept    = in_valid && in_ready;
    assign out_free  = !out_valid || out_ready;
    assign last_elem = accept && (elem_cnt_q == elem_w'(num_elems - 1));
    assign load_last = (row_cnt_q == idx_w'(num_rows - 1));

    always_comb begin
        row_asm = buf_q;
        for (int k = 0; k < num_elems; k++) begin
            if (elem_cnt_q == elem_w'(k)) begin
                row_asm[k*data_width +: data_width] = in_data;
            end
        end
    end

    // In STALL the buffer holds a finished row that is released by the next output transfer.
    always_comb begin
        state_d    = state_q;
        elem_cnt_d = elem_cnt_q;
        row_cnt_d  = row_cnt_q;
        buf_d      = buf_q;
        load       = 1'b0;
        load_row   = row_asm;
        case (state_q)
            FILL: begin
                if (accept) begin
                    buf_d      = row_asm;
                    elem_cnt_d = last_elem ? '0 : elem_cnt_q + elem_w'(1);
                    if (last_elem) begin
                        if (out_free) begin
                            load = 1'b1;
                        end else begin
                            state_d = STALL;
                        end
                    end
                end
            end
            STALL: begin
                if (out_valid && out_ready) begin
                    load     = 1'b1;
                    load_row = buf_q;
                    state_d  = FILL;
                end
            end
            default: state_d = FILL;
        endcase
        if (load) begin
            row_cnt_d = load_last ? '0 : row_cnt_q + idx_w'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FILL;
            elem_cnt_q <= '0;
            row_cnt_q  <= '0;
            buf_q      <= '0;
        end else begin
            state_q    <= state_d;
            elem_cnt_q <= elem_cnt_d;
            row_cnt_q  <= row_cnt_d;
            buf_q      <= buf_d;
        end
    end

    row_out_reg #(
        .row_width(row_width),
        .idx_width(idx_w)
    ) u_row_out_reg (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_row (load_row),
        .load_idx (row_cnt_q),
        .load_last(load_last),
        .out_ready(out_ready),
        .out_valid(out_valid),
        .out_row  (out_row),
        .out_idx  (out_row_idx),
        .out_last (out_last)
    );

endmodule

// File: tb/tb_matrix_row_loader.sv
// Self-checking bench for matrix_row_loader: directed scenarios with literal
// expectations plus randomized traffic compared against a queue-based row model.
module tb_matrix_row_loader;

    localparam int DW = 2;
    localparam int NE = 2;
    localparam int NR = 2;
    localparam int RW = DW * NE;
    localparam int IW = 1;

    logic          clk;
    logic          rst;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [RW-1:0] out_row;
    logic          out_valid;
    logic          out_ready;
    logic [IW-1:0] out_row_idx;
    logic          out_last;

    int errors;
    int checks;
    bit checking;

    matrix_row_loader #(
        .data_width(DW),
        .num_elems (NE),
        .num_rows  (NR)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_row    (out_row),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_row_idx(out_row_idx),
        .out_last   (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: rows completed but not yet taken downstream; at most one in the
    // output register and one parked behind it.
    typedef struct {
        logic [RW-1:0] row;
        int            idx;
    } row_t;

    row_t          pending[$];
    logic [DW-1:0] partial[$];
    int            m_row_idx;
    bit            m_xfer;
    bit            m_acc;
    row_t          m_new;

    always @(posedge clk) begin
        if (rst) begin
            pending.delete();
            partial.delete();
            m_row_idx = 0;
        end else begin
            m_xfer = (pending.size() > 0) && out_ready;
            m_acc  = in_valid && (pending.size() < 2);
            if (m_xfer) void'(pending.pop_front());
            if (m_acc) begin
                partial.push_back(in_data);
                if (partial.size() == NE) begin
                    m_new.row = '0;
                    for (int k = 0; k < NE; k++) m_new.row[k*DW +: DW] = partial[k];
                    m_new.idx = m_row_idx;
                    pending.push_back(m_new);
                    m_row_idx = (m_row_idx + 1) % NR;
                    partial.delete();
                end
            end
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
        end
    endtask

    always @(negedge clk) begin
        if (checking) begin
            checkOutput("model_in_ready", int'(in_ready), int'(!rst && pending.size() < 2));
            checkOutput("model_out_valid", int'(out_valid), int'(pending.size() > 0));
            if (out_valid && pending.size() > 0) begin
                checkOutput("model_out_row", int'(out_row), int'(pending[0].row));
                checkOutput("model_out_row_idx", int'(out_row_idx), pending[0].idx);
                checkOutput("model_out_last", int'(out_last), int'(pending[0].idx == NR - 1));
            end
        end
    end

    task automatic applyStimulus(input logic v, input logic [DW-1:0] d, input logic r);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
    endtask

    task automatic resetDut();
        @(posedge clk);
        #1;
        rst      = 1'b1;
        in_valid = 1'b0;
        #1;
        checkOutput("in_ready_during_reset", int'(in_ready), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("in_ready_after_reset", int'(in_ready), 1);
    endtask

    task automatic checkRow(input string name, input int row, input int idx, input int last);
        checkOutput({name, "_valid"}, int'(out_valid), 1);
        checkOutput({name, "_row"}, int'(out_row), row);
        checkOutput({name, "_idx"}, int'(out_row_idx), idx);
        checkOutput({name, "_last"}, int'(out_last), last);
    endtask

    int stream_elems[8] = '{1, 2, 3, 0, 2, 2, 1, 1};
    int stream_rows[4]  = '{9, 3, 10, 5};

    initial begin
        errors    = 0;
        checks    = 0;
        checking  = 1'b0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        resetDut();
        checking = 1'b1;

        checkOutput("reset_out_valid", int'(out_valid), 0);
        checkOutput("reset_out_row", int'(out_row), 0);
        checkOutput("reset_out_row_idx", int'(out_row_idx), 0);
        checkOutput("reset_out_last", int'(out_last), 0);

        // Basic: elements 1 then 2 form row 4'h9 one cycle after the last accept.
        applyStimulus(1'b1, 2'd1, 1'b1);
        applyStimulus(1'b1, 2'd2, 1'b1);
        applyStimulus(1'b0, 2'd0, 1'b1);
        checkRow("basic", 9, 0, 0);
        applyStimulus(1'b0, 2'd0, 1'b1);
        checkOutput("basic_valid_drops", int'(out_valid), 0);

        // Stream: back-to-back elements with no bubbles.
        resetDut();
        for (int i = 0; i < 9; i++) begin
            applyStimulus(i < 8, (i < 8) ? DW'(stream_elems[i]) : '0, 1'b1);
            checkOutput("stream_in_ready", int'(in_ready), 1);
            if (i >= 2 && (i % 2) == 0) begin
                checkRow("stream", stream_rows[i/2-1], (i/2-1) % 2, ((i/2-1) % 2 == 1) ? 1 : 0);
            end
        end

        // Backpressure: second row parks in STALL until one output transfer.
        resetDut();
        applyStimulus(1'b1, 2'd1, 1'b0);
        applyStimulus(1'b1, 2'd2, 1'b0);
        applyStimulus(1'b1, 2'd3, 1'b0);
        checkRow("bp_first", 9, 0, 0);
        applyStimulus(1'b1, 2'd0, 1'b0);
        checkRow("bp_hold", 9, 0, 0);
        applyStimulus(1'b0, 2'd0, 1'b0);
        checkOutput("bp_stall_in_ready", int'(in_ready), 0);
        checkRow("bp_stable", 9, 0, 0);
        applyStimulus(1'b1, 2'd3, 1'b1);
        checkOutput("bp_still_stalled", int'(in_ready), 0);
        applyStimulus(1'b0, 2'd0, 1'b0);
        checkRow("bp_second", 3, 1, 1);
        checkOutput("bp_in_ready_back", int'(in_ready), 1);

        // Simultaneous: last element and output transfer on the same edge.
        resetDut();
        applyStimulus(1'b1, 2'd1, 1'b0);
        applyStimulus(1'b1, 2'd2, 1'b0);
        applyStimulus(1'b1, 2'd3, 1'b0);
        applyStimulus(1'b1, 2'd0, 1'b1);
        checkRow("sim_first", 9, 0, 0);
        applyStimulus(1'b0, 2'd0, 1'b0);
        checkRow("sim_second", 3, 1, 1);
        checkOutput("sim_no_stall", int'(in_ready), 1);

        // Reset mid-row discards the partial element.
        resetDut();
        applyStimulus(1'b1, 2'd3, 1'b1);
        applyStimulus(1'b0, 2'd0, 1'b1);
        resetDut();
        applyStimulus(1'b1, 2'd1, 1'b1);
        applyStimulus(1'b1, 2'd2, 1'b1);
        applyStimulus(1'b0, 2'd0, 1'b1);
        checkRow("midrst", 9, 0, 0);

        // Random traffic with varying downstream pressure and occasional resets.
        for (int blk = 0; blk < 6; blk++) begin
            for (int i = 0; i < 400; i++) begin
                if ($urandom_range(0, 199) == 0) begin
                    resetDut();
                end else begin
                    applyStimulus($urandom_range(0, 3) != 0, DW'($urandom),
                                  (blk % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0));
                end
            end
        end

        applyStimulus(1'b0, '0, 1'b1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/matrix_row_loader.md
MATRIX_ROW_LOADER -- requirements
Module: matrix_row_loader

Interface
REQ-001 SHALL have parameter data_width, default 2: bit width of one matrix element.
REQ-002 SHALL have parameter num_elems, default 2: elements per row, which is the inner-product vector length.
REQ-003 SHALL have parameter num_rows, default 2: rows per matrix; SHALL be at least 1.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port in_data, input, data_width bits: serial matrix element, row-major order.
REQ-007 SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-008 SHALL have port in_ready, output, 1 bit: loader accepts in_data this cycle.
REQ-009 SHALL have port out_row, output, num_elems*data_width bits: packed row in the same layout the inner-product stage consumes; element k at bits [(k+1)*data_width-1 : k*data_width].
REQ-010 SHALL have port out_valid, output, 1 bit: out_row is valid.
REQ-011 SHALL have port out_ready, input, 1 bit: downstream inner-product stage accepts out_row.
REQ-012 SHALL have port out_row_idx, output, max(1,clog2(num_rows)) bits: row number of out_row.
REQ-013 SHALL have port out_last, output, 1 bit: high with out_valid when out_row_idx == num_rows-1.

Function
REQ-014 Input transfer SHALL occur on a rising edge where in_valid && in_ready; output transfer SHALL occur on a rising edge where out_valid && out_ready.
REQ-015 Each accepted element SHALL be written at position elem_cnt of the assembly buffer; elem_cnt SHALL increment by one and wrap from num_elems-1 to 0.
REQ-016 FSM states SHALL be FILL and STALL; FILL: in_ready=1; STALL: in_ready=0.
REQ-017 When the element at position num_elems-1 is accepted and the output register is free (out_valid==0, or an output transfer occurs on the same edge), the complete row SHALL load into the output register on that edge and state SHALL remain FILL.
REQ-018 When the element at position num_elems-1 is accepted and the output register is busy, the assembled row SHALL be kept and state SHALL go to STALL.
REQ-019 In STALL, the held row SHALL load into the output register on the edge of an output transfer, and state SHALL return to FILL on that edge.
REQ-020 Latency SHALL be one cycle: out_valid is high in the cycle after the edge that accepts the last element, when the output register is free.
REQ-021 Throughput SHALL be one element per cycle with out_ready held high; no bubbles occur between rows.
REQ-022 out_row, out_row_idx and out_last SHALL be stable while out_valid && !out_ready.
REQ-023 out_valid SHALL drop after an output transfer unless a new row loads on the same edge.
REQ-024 The row counter SHALL increment on each load into the output register and wrap from num_rows-1 to 0.
REQ-025 in_data SHALL be ignored when in_valid is low or in_ready is low.

Reset
REQ-026 While rst is high at a rising edge, the following SHALL be set: state=FILL, elem_cnt=0, row counter=0, out_valid=0, out_row=0, out_row_idx=0, out_last=0.
REQ-027 in_ready SHALL be 0 while rst is high and 1 in the first cycle after reset.
REQ-028 Reset mid-row or in STALL SHALL discard the partial or held row; the next accepted element is element 0 of row 0.

Structure
REQ-029 A shared package/include SHALL hold the clog2 constant function and the FILL/STALL state encodings.
REQ-030 The output register SHALL be a sub-module, row_out_reg, holding row, index and valid with the hold-until-ready rule.

Verification (data_width=2, num_elems=2, num_rows=2)
REQ-031 Basic: in 1 then 2, out_ready=1 -> out_row=4'h9, out_row_idx=0, out_last=0, with out_valid high one cycle after element 2 is accepted.
REQ-032 Stream: 8 back-to-back elements 1,2,3,0,2,2,1,1 with out_ready=1 -> rows 4'h9, 4'h3, 4'hA, 4'h5 with idx 0,1,0,1, out_last on the 2nd and 4th rows, and in_ready never low.
REQ-033 Backpressure: out_ready=0 while 4 elements are sent -> first row held stable, then STALL with in_ready=0; raising out_ready for one cycle -> second row appears next cycle and in_ready returns to 1.
REQ-034 Simultaneous: last element accepted on the same edge as an output transfer -> new row loads with no STALL entry and out_valid stays high.
REQ-035 Reset mid-row: accept one element of value 3, pulse rst, then send 1,2 -> out_row=4'h9, idx=0; no row containing 3 is ever presented.
